// File: rtl/mux_interleave_nxm_pkg.sv
// Shared constants, mode encodings and slot-counter sizing for the N-to-M interleaver.
package mux_pkg;

  localparam int         DEF_WIDTH   = 8;
  localparam logic [7:0] DEF_IDLE    = 8'h00;
  localparam logic       MODE_STRICT = 1'b0;
  localparam logic       MODE_PACK   = 1'b1;

  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    while ((32'sd1 <<< bits) < value) begin
      bits = bits + 1;
    end
    return bits;
  endfunction

  // A one-slot frame still needs a 1-bit counter so ports never collapse to zero width.
  function automatic int slot_width(input int ratio);
    int bits;
    bits = clog2(ratio);
    if (bits < 1) begin
      bits = 1;
    end else begin
      bits = bits;
    end
    return bits;
  endfunction

endpackage

// File: rtl/mux_interleave_nxm_if.sv
// Lane bus between the upstream striper and the interleaver: parallel inputs in, serialised lanes out.
interface mux_interleave_nxm_if
  import mux_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_IN  = 4,
  parameter int NUM_OUT = 2
);

  logic [NUM_IN*WIDTH-1:0]  entrada;
  logic [NUM_IN-1:0]        valid_entrada;
  logic                     skip_invalid;
  logic [NUM_OUT*WIDTH-1:0] salida;
  logic [NUM_OUT-1:0]       valid_salida;
  logic                     frame_sync;

  modport master (
    output entrada,
    output valid_entrada,
    output skip_invalid,
    input  salida,
    input  valid_salida,
    input  frame_sync
  );

  modport slave (
    input  entrada,
    input  valid_entrada,
    input  skip_invalid,
    output salida,
    output valid_salida,
    output frame_sync
  );

endinterface

// File: rtl/mux_interleave_nxm_lane_ser.sv
// One interleaver group: frame holding registers, strict/pack slot selection and the output register.
module mux_lane_ser
  import mux_pkg::*;
#(
  parameter int               WIDTH  = DEF_WIDTH,
  parameter int               RATIO  = 2,
  parameter logic [WIDTH-1:0] IDLE   = {WIDTH{1'b0}},
  parameter int               SLOT_W = slot_width(RATIO)
) (
  input  logic                    clk_2f,
  input  logic                    reset,
  input  logic [SLOT_W-1:0]       slot_q,
  input  logic [RATIO*WIDTH-1:0]  data_in,
  input  logic [RATIO-1:0]        valid_in,
  input  logic                    mode_in,
  output logic [WIDTH-1:0]        data_out,
  output logic                    valid_out
);

  logic [RATIO*WIDTH-1:0] hold_data_r;
  logic [RATIO-1:0]       hold_valid_r;
  logic                   hold_mode_r;

  logic                   first_slot_s;
  logic [RATIO*WIDTH-1:0] src_data_s;
  logic [RATIO-1:0]       src_valid_s;
  logic                   src_mode_s;
  logic [WIDTH-1:0]       pick_data_s;
  logic                   pick_valid_s;
  int                     set_count_s;

  logic [WIDTH-1:0]       data_r;
  logic                   valid_r;

  assign first_slot_s = (slot_q == {SLOT_W{1'b0}});

  // Frame capture: the whole group is latched on the slot-0 edge and held for the rest of the frame.
  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      hold_data_r  <= {(RATIO*WIDTH){1'b0}};
      hold_valid_r <= {RATIO{1'b0}};
      hold_mode_r  <= MODE_STRICT;
    end else if (first_slot_s) begin
      hold_data_r  <= data_in;
      hold_valid_r <= valid_in;
      hold_mode_r  <= mode_in;
    end else begin
      hold_data_r  <= hold_data_r;
      hold_valid_r <= hold_valid_r;
      hold_mode_r  <= hold_mode_r;
    end
  end

  // Slot 0 serialises straight from the live inputs because the holding registers fill on that same edge.
  always_comb begin
    src_data_s  = hold_data_r;
    src_valid_s = hold_valid_r;
    src_mode_s  = hold_mode_r;
    if (first_slot_s) begin
      src_data_s  = data_in;
      src_valid_s = valid_in;
      src_mode_s  = mode_in;
    end else begin
      src_data_s  = hold_data_r;
      src_valid_s = hold_valid_r;
      src_mode_s  = hold_mode_r;
    end
  end

  // Lane select: strict picks lane slot_q; pack picks the slot_q-th set valid bit in ascending order.
  always_comb begin
    pick_data_s  = IDLE;
    pick_valid_s = 1'b0;
    set_count_s  = 0;
    if (src_mode_s == MODE_PACK) begin
      for (int j = 0; j < RATIO; j++) begin
        if (src_valid_s[j]) begin
          if (set_count_s == int'(slot_q)) begin
            pick_data_s  = src_data_s[j*WIDTH +: WIDTH];
            pick_valid_s = 1'b1;
          end else begin
            pick_valid_s = pick_valid_s;
          end
          set_count_s = set_count_s + 1;
        end else begin
          set_count_s = set_count_s;
        end
      end
    end else begin
      for (int j = 0; j < RATIO; j++) begin
        if ((slot_q == SLOT_W'(j)) && src_valid_s[j]) begin
          pick_data_s  = src_data_s[j*WIDTH +: WIDTH];
          pick_valid_s = 1'b1;
        end else begin
          pick_valid_s = pick_valid_s;
        end
      end
    end
  end

  // Output register; reset drops any slot still in flight.
  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      data_r  <= IDLE;
      valid_r <= 1'b0;
    end else begin
      data_r  <= pick_data_s;
      valid_r <= pick_valid_s;
    end
  end

  assign data_out  = data_r;
  assign valid_out = valid_r;

endmodule

// File: rtl/mux_interleave_nxm.sv
// N-to-M time-division interleaver: shared slot counter, frame sync and one serialiser per output lane.
module mux_interleave_nxm
  import mux_pkg::*;
#(
  parameter int               WIDTH   = DEF_WIDTH,
  parameter int               NUM_IN  = 4,
  parameter int               NUM_OUT = 2,
  parameter logic [WIDTH-1:0] IDLE    = {WIDTH{1'b0}}
) (
  input  logic                 clk_2f,
  input  logic                 reset,
  mux_interleave_nxm_if.slave  bus
);

  localparam int RATIO  = NUM_IN / NUM_OUT;
  localparam int SLOT_W = slot_width(RATIO);

  logic [SLOT_W-1:0]        slot_q;
  logic                     frame_sync_r;
  logic [NUM_OUT*WIDTH-1:0] salida_s;
  logic [NUM_OUT-1:0]       valid_salida_s;

  // Free-running slot counter shared by every group; wraps after RATIO-1.
  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      slot_q <= {SLOT_W{1'b0}};
    end else if (slot_q == SLOT_W'(RATIO - 1)) begin
      slot_q <= {SLOT_W{1'b0}};
    end else begin
      slot_q <= slot_q + SLOT_W'(1);
    end
  end

  // Frame sync registered alongside the lane data so it marks the slot-0 output cycle.
  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      frame_sync_r <= 1'b0;
    end else begin
      frame_sync_r <= (slot_q == {SLOT_W{1'b0}});
    end
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_group
    mux_lane_ser #(
      .WIDTH  (WIDTH),
      .RATIO  (RATIO),
      .IDLE   (IDLE),
      .SLOT_W (SLOT_W)
    ) u_lane_ser (
      .clk_2f    (clk_2f),
      .reset     (reset),
      .slot_q    (slot_q),
      .data_in   (bus.entrada[g*RATIO*WIDTH +: RATIO*WIDTH]),
      .valid_in  (bus.valid_entrada[g*RATIO +: RATIO]),
      .mode_in   (bus.skip_invalid),
      .data_out  (salida_s[g*WIDTH +: WIDTH]),
      .valid_out (valid_salida_s[g])
    );
  end

  assign bus.salida       = salida_s;
  assign bus.valid_salida = valid_salida_s;
  assign bus.frame_sync   = frame_sync_r;

endmodule

// File: tb/tb_mux_interleave_nxm.sv
// Bench for mux_interleave_nxm at default parameters: directed frames plus a per-cycle reference model.
module tb_mux_interleave_nxm;

  localparam int         WIDTH   = 8;
  localparam int         NUM_IN  = 4;
  localparam int         NUM_OUT = 2;
  localparam int         RATIO   = NUM_IN / NUM_OUT;
  localparam logic [7:0] IDLE_V  = 8'h00;

  logic clk_2f;
  logic reset;

  int checks;
  int errors;

  mux_interleave_nxm_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT)) bus ();

  mux_interleave_nxm #(
    .WIDTH   (WIDTH),
    .NUM_IN  (NUM_IN),
    .NUM_OUT (NUM_OUT),
    .IDLE    (IDLE_V)
  ) dut (
    .clk_2f (clk_2f),
    .reset  (reset),
    .bus    (bus)
  );

  initial begin
    clk_2f = 1'b0;
    forever #5 clk_2f = ~clk_2f;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: list the frame's valid lanes, then index that list (pack) or the lane itself (strict).
  function automatic logic [NUM_OUT*(WIDTH+1)-1:0] model_outputs(
    input logic [NUM_IN*WIDTH-1:0] d, input logic [NUM_IN-1:0] v, input logic m, input int s);
    logic [NUM_OUT*WIDTH-1:0] dat;
    logic [NUM_OUT-1:0]       val;
    dat = '0;
    val = '0;
    for (int g = 0; g < NUM_OUT; g++) begin
      int picks[$];
      int lane;
      for (int j = 0; j < RATIO; j++) begin
        if (v[g*RATIO+j]) picks.push_back(g*RATIO + j);
      end
      lane = -1;
      if (m) begin
        if (s < picks.size()) lane = picks[s];
      end else begin
        if (v[g*RATIO+s]) lane = g*RATIO + s;
      end
      if (lane >= 0) begin
        dat[g*WIDTH +: WIDTH] = d[lane*WIDTH +: WIDTH];
        val[g] = 1'b1;
      end else begin
        dat[g*WIDTH +: WIDTH] = IDLE_V;
        val[g] = 1'b0;
      end
    end
    return {val, dat};
  endfunction

  int                       cyc;
  logic                     model_ok = 1'b0;
  logic [NUM_IN*WIDTH-1:0]  frame_d;
  logic [NUM_IN-1:0]        frame_v;
  logic                     frame_m;
  logic [NUM_OUT*WIDTH-1:0] exp_salida;
  logic [NUM_OUT-1:0]       exp_valid;
  logic                     exp_fs;

  always @(posedge clk_2f) begin
    model_ok <= 1'b1;
    if (!reset) begin
      cyc        <= 0;
      frame_d    <= '0;
      frame_v    <= '0;
      frame_m    <= 1'b0;
      exp_salida <= '0;
      exp_valid  <= '0;
      exp_fs     <= 1'b0;
    end else begin
      cyc    <= cyc + 1;
      exp_fs <= ((cyc % RATIO) == 0);
      if ((cyc % RATIO) == 0) begin
        frame_d <= bus.entrada;
        frame_v <= bus.valid_entrada;
        frame_m <= bus.skip_invalid;
        {exp_valid, exp_salida} <= model_outputs(bus.entrada, bus.valid_entrada,
                                                 bus.skip_invalid, 0);
      end else begin
        {exp_valid, exp_salida} <= model_outputs(frame_d, frame_v, frame_m, cyc % RATIO);
      end
    end
  end

  always @(negedge clk_2f) begin
    if (model_ok) begin
      check("model_salida", 32'(bus.salida), 32'(exp_salida));
      check("model_valid", 32'(bus.valid_salida), 32'(exp_valid));
      check("model_frame_sync", 32'(bus.frame_sync), 32'(exp_fs));
    end
  end

  task automatic lit(input string name, input logic [15:0] s, input logic [1:0] v, input logic fs);
    @(negedge clk_2f);
    check({name, "_salida"}, 32'(bus.salida), 32'(s));
    check({name, "_valid"}, 32'(bus.valid_salida), 32'(v));
    check({name, "_fsync"}, 32'(bus.frame_sync), 32'(fs));
  endtask

  task automatic set_frame(input logic [31:0] d, input logic [3:0] v, input logic m);
    bus.entrada       = d;
    bus.valid_entrada = v;
    bus.skip_invalid  = m;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    set_frame(32'h1234_5678, 4'b1010, 1'b1);

    lit("rst0", 16'h0000, 2'b00, 1'b0);
    set_frame(32'hDEAD_BEEF, 4'b0101, 1'b0);
    lit("rst1", 16'h0000, 2'b00, 1'b0);
    set_frame(32'h5A5A_C3C3, 4'b1111, 1'b1);
    lit("rst2", 16'h0000, 2'b00, 1'b0);

    set_frame(32'hB1B0_A1A0, 4'b1111, 1'b0);
    reset = 1'b1;
    lit("strict_s0", 16'hB0A0, 2'b11, 1'b1);
    lit("strict_s1", 16'hB1A1, 2'b11, 1'b0);
    lit("strict_rep_s0", 16'hB0A0, 2'b11, 1'b1);
    lit("strict_rep_s1", 16'hB1A1, 2'b11, 1'b0);

    set_frame(32'hB1B0_A1A0, 4'b1110, 1'b0);
    lit("strict_hole_s0", 16'hB000, 2'b10, 1'b1);
    lit("strict_hole_s1", 16'hB1A1, 2'b11, 1'b0);

    set_frame(32'hB1B0_A1A0, 4'b0110, 1'b1);
    lit("pack_s0", 16'hB0A1, 2'b11, 1'b1);
    lit("pack_s1", 16'h0000, 2'b00, 1'b0);

    set_frame(32'h0000_0000, 4'b0000, 1'b1);
    lit("pack_empty_s0", 16'h0000, 2'b00, 1'b1);
    lit("pack_empty_s1", 16'h0000, 2'b00, 1'b0);

    set_frame(32'hB1B0_A1A0, 4'b1110, 1'b0);
    lit("mid_s0", 16'hB000, 2'b10, 1'b1);
    bus.entrada[15:8] = 8'hFF;
    bus.skip_invalid  = 1'b1;
    lit("mid_s1", 16'hB1A1, 2'b11, 1'b0);
    lit("mid_next_s0", 16'hB0FF, 2'b11, 1'b1);
    lit("mid_next_s1", 16'hB100, 2'b10, 1'b0);

    set_frame(32'hB1B0_A1A0, 4'b1111, 1'b0);
    lit("rmid_s0", 16'hB0A0, 2'b11, 1'b1);
    reset = 1'b0;
    lit("rmid_abort", 16'h0000, 2'b00, 1'b0);
    reset = 1'b1;
    lit("rmid_restart_s0", 16'hB0A0, 2'b11, 1'b1);
    lit("rmid_restart_s1", 16'hB1A1, 2'b11, 1'b0);

    // Vectors changing every cycle, including mid-frame, checked by the model only.
    for (int i = 0; i < 16; i++) begin
      bus.entrada       = 32'(i) * 32'h0103_0507 + 32'h1020_3040;
      bus.valid_entrada = 4'(i * 5 + 3);
      bus.skip_invalid  = 1'((i >> 1) & 1);
      @(negedge clk_2f);
    end

    repeat (2) @(negedge clk_2f);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
